// File: rtl/neo_frame_buffer.sv
// Double-buffered pixel store for an addressable-LED chain: writes fill the back
// bank, a swap exchanges banks between frames, and one frame streams out pixel by pixel.
module neo_frame_buffer #(
  parameter int NUM_PIX = 8,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              swap,
  input  logic              frame_start,
  output logic              px_valid,
  input  logic              px_ready,
  output logic [23:0]       px_data,
  output logic              px_last,
  output logic              frame_done,
  output logic              busy,
  output logic              swap_pending,
  output logic              active_bank,
  output logic              start_ovr
);

  // Handshake: a pixel transfers on a rising edge where px_valid & px_ready are both 1;
  // px_valid never depends combinationally on px_ready and data holds until transfer.

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

  localparam int                DEPTH     = 2 ** (ADDR_W + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_PIX - 1);
  localparam logic [ADDR_W:0]   NUM_PIX_W = (ADDR_W + 1)'(NUM_PIX);

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              px_valid_q;
  logic [23:0]       px_data_q;
  logic              px_last_q;
  logic              frame_done_q;
  logic              swap_pending_q;
  logic              active_bank_q;
  logic              start_ovr_q;

  // Physical word address is {bank, pixel index}; each bank spans 2**ADDR_W slots.
  logic [23:0] mem_q [DEPTH];

  logic wr_ok;
  assign wr_ok = wr_en && ({1'b0, wr_addr} < NUM_PIX_W);

  function automatic logic [23:0] bitrev(input logic [23:0] w);
    logic [23:0] r;
    for (int i = 0; i < 24; i++) r[i] = w[23-i];
    return r;
  endfunction

  // RAM contents survive reset; writes only ever target the back bank.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[{~active_bank_q, wr_addr}] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      px_valid_q     <= 1'b0;
      px_data_q      <= '0;
      px_last_q      <= 1'b0;
      frame_done_q   <= 1'b0;
      swap_pending_q <= 1'b0;
      active_bank_q  <= 1'b0;
      start_ovr_q    <= 1'b0;
    end else begin
      if (swap) swap_pending_q <= 1'b1;
      if (frame_start && (state_q != IDLE)) start_ovr_q <= 1'b1;

      case (state_q)
        IDLE: begin
          // A swap seen in the same cycle as frame_start lands before the fetch.
          if (swap || swap_pending_q) begin
            active_bank_q  <= ~active_bank_q;
            swap_pending_q <= 1'b0;
          end
          if (frame_start) begin
            idx_q   <= '0;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          px_data_q  <= bitrev(mem_q[{active_bank_q, idx_q}]);
          px_last_q  <= (idx_q == LAST_IDX);
          px_valid_q <= 1'b1;
          state_q    <= PRESENT;
        end
        PRESENT: begin
          if (px_valid_q && px_ready) begin
            px_valid_q <= 1'b0;
            px_last_q  <= 1'b0;
            if (idx_q == LAST_IDX) begin
              frame_done_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              idx_q   <= idx_q + ADDR_W'(1);
              state_q <= FETCH;
            end
          end
        end
        DONE: begin
          frame_done_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign px_valid     = px_valid_q;
  assign px_data      = px_data_q;
  assign px_last      = px_last_q;
  assign frame_done   = frame_done_q;
  assign busy         = (state_q != IDLE);
  assign swap_pending = swap_pending_q;
  assign active_bank  = active_bank_q;
  assign start_ovr    = start_ovr_q;

endmodule

// File: tb/tb_neo_frame_buffer.sv
// Directed bench for neo_frame_buffer: bank swap timing, streaming latency,
// back-pressure stall, ignored starts/writes and mid-frame reset.
module tb_neo_frame_buffer;

  localparam int NUM_PIX = 8;
  localparam int ADDR_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              swap;
  logic              frame_start;
  logic              px_valid;
  logic              px_ready;
  logic [23:0]       px_data;
  logic              px_last;
  logic              frame_done;
  logic              busy;
  logic              swap_pending;
  logic              active_bank;
  logic              start_ovr;

  int n_pass  = 0;
  int n_total = 0;

  neo_frame_buffer #(.NUM_PIX(NUM_PIX), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .swap         (swap),
    .frame_start  (frame_start),
    .px_valid     (px_valid),
    .px_ready     (px_ready),
    .px_data      (px_data),
    .px_last      (px_last),
    .frame_done   (frame_done),
    .busy         (busy),
    .swap_pending (swap_pending),
    .active_bank  (active_bank),
    .start_ovr    (start_ovr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic write_px(input logic [ADDR_W-1:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (px_valid !== 1'b1 && n < 6) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, px_valid}, 32'd1);
  endtask

  function automatic logic [23:0] rev24(input logic [23:0] w);
    logic [23:0] r;
    for (int i = 0; i < 24; i++) r[i] = w[23-i];
    return r;
  endfunction

  function automatic logic [23:0] pat0(input int k);
    logic [23:0] v;
    v = (k == 0) ? 24'hFE0000 : (24'hC00000 | 24'(k));
    return v;
  endfunction

  initial begin
    logic [23:0] held;
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    swap = 1'b0; frame_start = 1'b0; px_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_valid",   {31'd0, px_valid},     32'd0);
    chk("rst_last",    {31'd0, px_last},      32'd0);
    chk("rst_done",    {31'd0, frame_done},   32'd0);
    chk("rst_busy",    {31'd0, busy},         32'd0);
    chk("rst_pending", {31'd0, swap_pending}, 32'd0);
    chk("rst_active",  {31'd0, active_bank},  32'd0);
    chk("rst_ovr",     {31'd0, start_ovr},    32'd0);
    chk("rst_data",    {8'd0, px_data},       32'd0);
    rst = 1'b1;
    tick();

    // Frame 1: back bank 1 gets k, swap, stream with ready held high
    for (int k = 0; k < NUM_PIX; k++) write_px(ADDR_W'(k), 24'(k));
    swap = 1'b1; tick(); swap = 1'b0;
    chk("swap_idle_active",  {31'd0, active_bank},  32'd1);
    chk("swap_idle_pending", {31'd0, swap_pending}, 32'd0);

    px_ready = 1'b1;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("f1_fetch_busy",  {31'd0, busy},     32'd1);
    chk("f1_fetch_valid", {31'd0, px_valid}, 32'd0);
    for (int k = 0; k < NUM_PIX; k++) begin
      tick();
      chk($sformatf("f1_valid_%0d", k), {31'd0, px_valid},   32'd1);
      chk($sformatf("f1_data_%0d", k),  {8'd0, px_data},     {8'd0, rev24(24'(k))});
      chk($sformatf("f1_last_%0d", k),  {31'd0, px_last},    (k == NUM_PIX-1) ? 32'd1 : 32'd0);
      chk($sformatf("f1_done_%0d", k),  {31'd0, frame_done}, 32'd0);
      if (k == 1) chk("f1_pix1_const", {8'd0, px_data}, 32'h00800000);
      tick();
      chk($sformatf("f1_gap_%0d", k),   {31'd0, px_valid},   32'd0);
      chk($sformatf("f1_fdone_%0d", k), {31'd0, frame_done}, (k == NUM_PIX-1) ? 32'd1 : 32'd0);
    end
    tick();
    chk("f1_done_drop", {31'd0, frame_done}, 32'd0);
    chk("f1_idle",      {31'd0, busy},       32'd0);

    // Frame 2: back bank 0, stall on pixel 3, restart at 2, swap at 4
    for (int k = 0; k < NUM_PIX; k++) write_px(ADDR_W'(k), pat0(k));
    swap = 1'b1; tick(); swap = 1'b0;
    chk("f2_active", {31'd0, active_bank}, 32'd0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int k = 0; k < NUM_PIX; k++) begin
      wait_valid($sformatf("f2_wait_%0d", k));
      chk($sformatf("f2_data_%0d", k), {8'd0, px_data},  {8'd0, rev24(pat0(k))});
      chk($sformatf("f2_last_%0d", k), {31'd0, px_last}, (k == NUM_PIX-1) ? 32'd1 : 32'd0);
      if (k == 0) chk("f2_fe0000_const", {8'd0, px_data}, 32'h0000007F);
      if (k == 3) begin
        held = px_data;
        px_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
          tick();
          chk($sformatf("stall_valid_%0d", c), {31'd0, px_valid}, 32'd1);
          chk($sformatf("stall_data_%0d", c),  {8'd0, px_data},   {8'd0, held});
        end
        px_ready = 1'b1;
      end
      if (k == 4) swap = 1'b1;
      if (k == 2) frame_start = 1'b1;
      tick();
      swap = 1'b0; frame_start = 1'b0;
      chk($sformatf("f2_gap_%0d", k), {31'd0, px_valid}, 32'd0);
      if (k == 2) begin
        chk("f2_ovr",       {31'd0, start_ovr}, 32'd1);
        chk("f2_ovr_busy",  {31'd0, busy},      32'd1);
      end
      if (k == 4) begin
        chk("f2_swap_pending", {31'd0, swap_pending}, 32'd1);
        chk("f2_swap_active",  {31'd0, active_bank},  32'd0);
      end
    end
    chk("f2_fdone",          {31'd0, frame_done},   32'd1);
    chk("f2_done_pending",   {31'd0, swap_pending}, 32'd1);
    chk("f2_done_active",    {31'd0, active_bank},  32'd0);
    tick();
    chk("f2_idle_fdone",     {31'd0, frame_done},   32'd0);
    chk("f2_idle_busy",      {31'd0, busy},         32'd0);
    chk("f2_idle_pending",   {31'd0, swap_pending}, 32'd1);
    chk("f2_idle_active",    {31'd0, active_bank},  32'd0);
    tick();
    chk("f2_applied_active",  {31'd0, active_bank},  32'd1);
    chk("f2_applied_pending", {31'd0, swap_pending}, 32'd0);

    // Out-of-range write, then swap coincident with start; junk writes hit the back bank
    write_px(ADDR_W'(9), 24'h123456);
    swap = 1'b1; frame_start = 1'b1; tick(); swap = 1'b0; frame_start = 1'b0;
    chk("f3_active",  {31'd0, active_bank},  32'd0);
    chk("f3_pending", {31'd0, swap_pending}, 32'd0);
    chk("f3_busy",    {31'd0, busy},         32'd1);
    wr_en = 1'b1; wr_addr = ADDR_W'(1); wr_data = 24'hFFFFFF;
    for (int k = 0; k <= 5; k++) begin
      wait_valid($sformatf("f3_wait_%0d", k));
      chk($sformatf("f3_data_%0d", k), {8'd0, px_data}, {8'd0, rev24(pat0(k))});
      if (k < 5) begin
        tick();
        chk($sformatf("f3_gap_%0d", k), {31'd0, px_valid}, 32'd0);
      end
    end
    wr_en = 1'b0;

    // Reset at pixel 5
    rst = 1'b0; tick(); rst = 1'b1;
    chk("mrst_valid",  {31'd0, px_valid},    32'd0);
    chk("mrst_busy",   {31'd0, busy},        32'd0);
    chk("mrst_fdone",  {31'd0, frame_done},  32'd0);
    chk("mrst_ovr",    {31'd0, start_ovr},   32'd0);
    chk("mrst_active", {31'd0, active_bank}, 32'd0);
    chk("mrst_data",   {8'd0, px_data},      32'd0);

    // Frame 4: bank 0 contents intact after reset and the ignored write
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int k = 0; k < NUM_PIX; k++) begin
      wait_valid($sformatf("f4_wait_%0d", k));
      chk($sformatf("f4_data_%0d", k), {8'd0, px_data},  {8'd0, rev24(pat0(k))});
      chk($sformatf("f4_last_%0d", k), {31'd0, px_last}, (k == NUM_PIX-1) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("f4_gap_%0d", k),   {31'd0, px_valid},   32'd0);
      chk($sformatf("f4_fdone_%0d", k), {31'd0, frame_done}, (k == NUM_PIX-1) ? 32'd1 : 32'd0);
    end
    tick();
    chk("f4_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/neo_frame_buffer.md
NEO_FRAME_BUFFER -- requirements
Module: neo_frame_buffer

Interface
REQ-001 SHALL have parameter NUM_PIX, default 8, meaning the number of pixels per frame (2..64).
REQ-002 SHALL have parameter ADDR_W, default 3, meaning the pixel address width (2**ADDR_W >= NUM_PIX).
REQ-003 SHALL have port clk  input  1  meaning the single 12 MHz system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, synchronous and active-low.
REQ-005 SHALL have port wr_en  input  1  meaning write strobe into the back bank.
REQ-006 SHALL have port wr_addr  input  ADDR_W  meaning the pixel index to write.
REQ-007 SHALL have port wr_data  input  24  meaning the colour word {G[7:0],R[7:0],B[7:0]}.
REQ-008 SHALL have port swap  input  1  meaning a pulse requesting a front/back bank exchange.
REQ-009 SHALL have port frame_start  input  1  meaning a pulse requesting streaming of one frame from the front bank.
REQ-010 SHALL have port px_valid  output  1  meaning px_data holds a valid pixel.
REQ-011 SHALL have port px_ready  input  1  meaning the downstream serializer accepts px_data this cycle.
REQ-012 SHALL have port px_data  output  24  meaning the pixel word in transmit order: bit 0 is sent first.
REQ-013 SHALL have port px_last  output  1  meaning px_data is pixel NUM_PIX-1.
REQ-014 SHALL have port frame_done  output  1  meaning a one-cycle pulse after the last pixel is accepted.
REQ-015 SHALL have port busy  output  1  meaning a frame is in progress (state != IDLE).
REQ-016 SHALL have port swap_pending  output  1  meaning a swap is requested but not yet applied.
REQ-017 SHALL have port active_bank  output  1  meaning the index of the front bank.
REQ-018 SHALL have port start_ovr  output  1  meaning sticky: frame_start was received while busy.

Function
REQ-019 SHALL store 2 x NUM_PIX x 24-bit words with a synchronous read of 1-cycle latency.
REQ-020 SHALL write wr_data to bank ~active_bank at wr_addr when wr_en=1 and wr_addr < NUM_PIX; wr_addr >= NUM_PIX SHALL be ignored.
REQ-021 SHALL never alter front-bank contents through writes.
REQ-022 SHALL drive px_data as the full 24-bit bit-reversal of the stored word: px_data[i] = word[23-i], so G[7] is sent first.
REQ-023 SHALL implement an FSM with states IDLE, FETCH, PRESENT and DONE.
REQ-024 SHALL go from IDLE to FETCH on frame_start, clearing the pixel index to 0.
REQ-025 SHALL go from FETCH to PRESENT after one cycle, registering px_data and asserting px_valid.
REQ-026 SHALL, in PRESENT, hold px_valid, px_data and px_last stable until px_valid & px_ready.
REQ-027 SHALL, on a handshake with index < NUM_PIX-1, increment the index, deassert px_valid and go to FETCH.
REQ-028 SHALL, on a handshake with index = NUM_PIX-1, deassert px_valid and go to DONE.
REQ-029 SHALL assert frame_done for exactly one cycle in DONE and then go to IDLE.
REQ-030 SHALL give a latency from frame_start (cycle N) to the first px_valid of cycle N+2, and from each handshake to the next px_valid of 2 cycles.
REQ-031 SHALL set swap_pending on swap; multiple swaps before application SHALL collapse into one.
REQ-032 SHALL apply a pending swap only in IDLE: toggle active_bank, clear swap_pending.
REQ-033 SHALL, when swap and frame_start coincide in IDLE, apply the swap first so the frame streams the new front bank.
REQ-034 SHALL defer a swap arriving while busy until the cycle after DONE; the current frame is unaffected.
REQ-035 SHALL ignore frame_start while busy and set start_ovr, which clears only on reset.
REQ-036 SHALL apply a write and a read to the same physical word in the same cycle without corrupting the read; the read returns the old data.
REQ-037 SHALL keep px_valid low whenever px_ready=1 and state != PRESENT; there is no combinational ready-to-valid path.

Reset
REQ-038 SHALL, while rst=0 at a clock edge, set state IDLE, index 0, px_valid 0, px_last 0, frame_done 0, busy 0, swap_pending 0, active_bank 0, start_ovr 0, and px_data 0.
REQ-039 SHALL abort a frame in progress on reset mid-frame, with no frame_done emitted; RAM contents SHALL be retained and not cleared.

Verification
REQ-040 SHALL be verified by: NUM_PIX=8; write back bank 0..7 = 24'h000001*k; swap; frame_start with px_ready=1 -> 8 pixels each 2 cycles apart, px_data = bitrev(k), px_last only on k=7, one frame_done.
REQ-041 SHALL be verified by: wr_data=24'hFE0000 -> px_data=24'h00007F.
REQ-042 SHALL be verified by: px_ready held 0 for 20 cycles on pixel 3 -> px_valid and px_data stable throughout, index unchanged.
REQ-043 SHALL be verified by: swap at pixel 4 of a frame -> frame finishes from old bank; active_bank toggles the cycle after frame_done; swap_pending 1 in between.
REQ-044 SHALL be verified by: frame_start mid-frame -> ignored, start_ovr=1; write to wr_addr=9 -> no RAM change.
REQ-045 SHALL be verified by: rst=0 at pixel 5 -> next cycle px_valid=0 and busy=0; a new frame_start streams from pixel 0 with the data intact.
